// File: rtl/round_ctrl.sv
// Block-cipher round controller: takes one block request, runs the external round
// counter, and turns its count into round enables and forward/reverse key indices.
//
// state | meaning
// IDLE  | waiting for a request; only accepts once the counter has cleared
// RUN   | counter running; one round_en per count value 0..ROUNDS-1
// DONE  | result presented on out_valid until the consumer takes it
module round_ctrl #(
  parameter int ROUNDS = 16,
  parameter int CNT_W  = 5,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic             abort,
  output logic             start,
  input  logic [CNT_W-1:0] cnt,
  input  logic             cnt_end,
  output logic             round_en,
  output logic [IDX_W-1:0] key_idx,
  output logic             first_round,
  output logic             last_round,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             mode_q,
  output logic             err
);

  localparam int WD_W = $clog2(ROUNDS + 3);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(ROUNDS);
  // Watchdog fires on the cycle it would reach ROUNDS+2; a healthy run leaves RUN at ROUNDS.
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(ROUNDS + 1);

  generate
    if (IDX_W > CNT_W || (1 << IDX_W) < ROUNDS || (1 << CNT_W) <= ROUNDS) begin : g_param_check
      $error("round_ctrl: CNT_W/IDX_W too narrow for ROUNDS");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state, state_d;
  logic            start_d;
  logic            out_valid_d;
  logic            mode_q_d;
  logic            err_d;
  logic [WD_W-1:0] wd, wd_d;
  logic [CNT_W-1:0] key_sel;

  assign key_sel = mode_q ? (CNT_LAST - cnt) : cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      start     <= 1'b0;
      out_valid <= 1'b0;
      mode_q    <= 1'b0;
      err       <= 1'b0;
      wd        <= '0;
    end else begin
      state     <= state_d;
      start     <= start_d;
      out_valid <= out_valid_d;
      mode_q    <= mode_q_d;
      err       <= err_d;
      wd        <= wd_d;
    end
  end

  always_comb begin
    state_d     = state;
    start_d     = start;
    out_valid_d = out_valid;
    mode_q_d    = mode_q;
    err_d       = err;
    wd_d        = wd;
    in_ready    = 1'b0;
    round_en    = 1'b0;
    key_idx     = '0;
    first_round = 1'b0;
    last_round  = 1'b0;

    case (state)
      S_IDLE: begin
        in_ready = (cnt == '0) && !cnt_end;
        if (in_valid && in_ready) begin
          mode_q_d = mode;
          start_d  = 1'b1;
          wd_d     = '0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        round_en    = !cnt_end && (cnt < CNT_TERM);
        key_idx     = key_sel[IDX_W-1:0];
        first_round = round_en && (cnt == '0);
        last_round  = round_en && (cnt == CNT_LAST);
        wd_d        = wd + WD_W'(1);
        if (abort) begin
          start_d     = 1'b0;
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (cnt_end) begin
          start_d     = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (wd == WD_LIMIT) begin
          err_d   = 1'b1;
          start_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      S_DONE: begin
        // abort beats a simultaneous out_ready: the result is dropped
        if (abort) begin
          start_d     = 1'b0;
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        start_d     = 1'b0;
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

endmodule
